// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the memory port arbiter
package arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  localparam logic [1:0] SEL_IDLE = 2'b11;
  localparam int         NUM_REQ  = 3;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    if (idx < 2'(NUM_REQ)) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner selection over three requesters
module rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         rr_ptr,
  output logic               any,
  output logic [1:0]         winner
);

  logic [1:0] base;
  logic [2:0] idx;

  // Scan from the farthest slot back to rr_ptr so the closest set bit wins.
  always_comb begin
    any    = |req;
    winner = 2'd0;
    base   = (rr_ptr == 2'd3) ? 2'd0 : rr_ptr;
    idx    = 3'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = {1'b0, base} + 3'(i);
      if (idx >= 3'(NUM_REQ)) idx = idx - 3'(NUM_REQ);
      if (req[idx[1:0]]) winner = idx[1:0];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter for one shared data-memory port
// Optional abort of stalled accesses enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_we,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] done,
  output logic [1:0]         sel2,
  output logic               mem_valid,
  output logic               mem_we,
  input  logic               mem_ready,
  output logic               busy,
  output logic               err
);

  arb_state_t         state_q, state_d;
  logic [1:0]         winner_q, winner_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] gnt_d, done_d;
  logic [1:0]         sel2_d;
  logic               mem_valid_d, mem_we_d, busy_d, err_d;
  logic               pick_any;
  logic [1:0]         pick_winner;
  logic               timeout_hit;

  rr_pick u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .any    (pick_any),
    .winner (pick_winner)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 5) ? $clog2(TIMEOUT_CYCLES) : 5;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Held at zero while idle so every grant starts a fresh count.
  always_comb begin
    cnt_d       = '0;
    timeout_hit = 1'b0;
    if (state_q == BUSY) begin
      timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
      cnt_d       = mem_ready ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt;
    sel2_d      = sel2;
    mem_valid_d = mem_valid;
    mem_we_d    = mem_we;
    busy_d      = busy;
    done_d      = '0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d     = BUSY;
          winner_d    = pick_winner;
          gnt_d       = onehot(pick_winner);
          sel2_d      = pick_winner;
          mem_valid_d = 1'b1;
          mem_we_d    = req_we[pick_winner];
          busy_d      = 1'b1;
        end
      end
      BUSY: begin
        // A real completion in the deadline cycle takes precedence over the abort.
        if (mem_ready || timeout_hit) begin
          state_d     = IDLE;
          done_d      = onehot(winner_q);
          err_d       = ~mem_ready;
          gnt_d       = '0;
          sel2_d      = SEL_IDLE;
          mem_valid_d = 1'b0;
          mem_we_d    = 1'b0;
          busy_d      = 1'b0;
          rr_ptr_d    = (winner_q == 2'd2) ? 2'd0 : winner_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      winner_q  <= 2'd0;
      rr_ptr_q  <= 2'd0;
      gnt       <= '0;
      done      <= '0;
      sel2      <= SEL_IDLE;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt       <= gnt_d;
      done      <= done_d;
      sel2      <= sel2_d;
      mem_valid <= mem_valid_d;
      mem_we    <= mem_we_d;
      busy      <= busy_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic [2:0] req_we = 3'b000;
  logic       mem_ready = 1'b0;
  logic [2:0] gnt, done;
  logic [1:0] sel2;
  logic       mem_valid, mem_we, busy, err;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_we    (req_we),
    .gnt       (gnt),
    .done      (done),
    .sel2      (sel2),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .busy      (busy),
    .err       (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".gnt"}, 32'(gnt), 0);
    chk({tag, ".sel2"}, 32'(sel2), 3);
    chk({tag, ".valid"}, 32'(mem_valid), 0);
    chk({tag, ".done"}, 32'(done), 0);
  endtask

  logic [2:0] rr_gnt  [8] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
  logic [2:0] rr_done [8] = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};

  initial begin
    // reset held with all requests asserted
    rst = 1'b1; req = 3'b111;
    tick(); chk_idle("rst1"); chk("rst1.busy", 32'(busy), 0);
    tick(); chk_idle("rst2"); chk("rst2.err", 32'(err), 0);

    // single write access from fetch
    rst = 1'b0; req = 3'b010; req_we = 3'b010;
    tick();
    chk("single.gnt", 32'(gnt), 32'b010);
    chk("single.sel2", 32'(sel2), 1);
    chk("single.we", 32'(mem_we), 1);
    chk("single.valid", 32'(mem_valid), 1);
    chk("single.busy", 32'(busy), 1);
    tick();
    chk("single.hold", 32'(gnt), 32'b010);
    chk("single.nodone", 32'(done), 0);
    mem_ready = 1'b1;
    tick();
    chk("single.done", 32'(done), 32'b010);
    chk("single.sel2idle", 32'(sel2), 3);
    chk("single.gnt0", 32'(gnt), 0);
    chk("single.we0", 32'(mem_we), 0);
    mem_ready = 1'b0; req = 3'b000; req_we = 3'b000;
    tick();
    chk("single.pulse", 32'(done), 0);

    // round-robin from a fresh pointer
    rst = 1'b1; tick(); rst = 1'b0;
    req = 3'b111; mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("rr%0d.gnt", i), 32'(gnt), 32'(rr_gnt[i]));
      chk($sformatf("rr%0d.done", i), 32'(done), 32'(rr_done[i]));
    end
    req = 3'b000; mem_ready = 1'b0;
    tick();

    // reset in the middle of a transaction
    req = 3'b001;
    tick();
    chk("mid.gnt", 32'(gnt), 32'b001);
    rst = 1'b1;
    tick();
    chk_idle("mid.rst"); chk("mid.busy", 32'(busy), 0);
    rst = 1'b0; req = 3'b000; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mid%0d.nodone", i), 32'(done), 0);
    end

    // mem_ready while idle is ignored
    tick();
    chk_idle("ign"); chk("ign.busy", 32'(busy), 0);
    mem_ready = 1'b0; req = 3'b100;
    tick();
    chk("drop.gnt", 32'(gnt), 32'b100);
    chk("drop.sel2", 32'(sel2), 2);
    req = 3'b000;
    tick();
    chk("drop.hold", 32'(gnt), 32'b100);
    chk("drop.busy", 32'(busy), 1);
    mem_ready = 1'b1;
    tick();
    chk("drop.done", 32'(done), 32'b100);
    mem_ready = 1'b0; req = 3'b101;
    tick();
    chk("wrap.gnt", 32'(gnt), 32'b001);
    chk("wrap.sel2", 32'(sel2), 0);
    mem_ready = 1'b1;
    tick();
    chk("wrap.done", 32'(done), 32'b001);
    mem_ready = 1'b0; req = 3'b000;
    tick();

    // stalled access
    req = 3'b010;
    tick();
    chk("to.gnt", 32'(gnt), 32'b010);
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("to%0d.done", i), 32'(done), 0);
    end
    tick();
    chk("to.done", 32'(done), 32'b010);
    chk("to.err", 32'(err), 1);
    chk("to.gnt0", 32'(gnt), 0);
    tick();
    chk("to.errpulse", 32'(err), 0);
    chk("to.regnt", 32'(gnt), 32'b010);
    for (int i = 1; i <= 3; i++) tick();
    mem_ready = 1'b1;
    tick();
    chk("tor.done", 32'(done), 32'b010);
    chk("tor.err", 32'(err), 0);
    mem_ready = 1'b0; req = 3'b000;
`else
    begin
      logic seen_done = 1'b0;
      logic seen_err  = 1'b0;
      for (int i = 0; i < 100; i++) begin
        tick();
        seen_done |= |done;
        seen_err  |= err;
      end
      chk("noto.done", 32'(seen_done), 0);
      chk("noto.err", 32'(seen_err), 0);
      chk("noto.busy", 32'(busy), 1);
      chk("noto.gnt", 32'(gnt), 32'b010);
    end
`endif
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
